// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM-stage load/store unit.
//   size_e      - access size code; the same encoding is forwarded to Byte_unit sel
//   lsu_state_e - sequencer states
//   BE_WIDTH    - byte-enable width for the 32-bit data bus
package mem_pkg;

  localparam int LSU_DATA_WIDTH = 32;
  localparam int BE_WIDTH       = LSU_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/mem_store_align.sv
// mem_store_align: combinational alignment check and store lane steering.
// Ports:
//   we         in  1 = store; byte enables are forced to 0 for loads
//   size       in  access size code (size_e encoding)
//   offset     in  byte offset within the word (addr[1:0])
//   wdata      in  right-justified store data
//   misaligned out half on odd address, word not on a word boundary, or illegal size
//   be         out byte enables for the data memory
//   wdata_rep  out store data replicated across the byte lanes
module mem_store_align
  import mem_pkg::*;
(
  input  logic                      we,
  input  logic [1:0]                size,
  input  logic [1:0]                offset,
  input  logic [LSU_DATA_WIDTH-1:0] wdata,
  output logic                      misaligned,
  output logic [BE_WIDTH-1:0]       be,
  output logic [LSU_DATA_WIDTH-1:0] wdata_rep
);

  logic [BE_WIDTH-1:0] be_raw;

  // Decode size/offset into alignment flag, raw enables and replicated data.
  always_comb begin
    misaligned = 1'b0;
    be_raw     = 4'b0000;
    wdata_rep  = wdata;
    case (size)
      SZ_BYTE: begin
        be_raw    = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        misaligned = offset[0];
        be_raw     = 4'b0011 << offset;
        wdata_rep  = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        misaligned = (offset != 2'b00);
        be_raw     = 4'b1111;
      end
      default: begin
        misaligned = 1'b1;
        be_raw     = 4'b0000;
      end
    endcase
  end

  // Loads never drive byte enables.
  assign be = we ? be_raw : 4'b0000;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer (IDLE -> REQ -> [WAIT] -> IDLE).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_*                      load/store request from the EX/MEM register
//   dmem_req_valid/ready, dmem_we/addr/be/wdata
//                              data-memory request, held stable until accepted
//   dmem_rsp_valid/rdata       data-memory read response (used only in WAIT)
//   rsp_valid/data/sel         completion pulse, lane-0 aligned load word, size code
//   misaligned                 one-cycle reject pulse
//   stall                      pipeline hold, high whenever not IDLE
// All outputs come straight from flops.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [BE_WIDTH-1:0]   dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rsp_rdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_sel,
  output logic                  misaligned,
  output logic                  stall
);

  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            offset_q, offset_d;
  logic                  dmem_req_valid_q, dmem_req_valid_d;
  logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [BE_WIDTH-1:0]   dmem_be_q, dmem_be_d;
  logic [DATA_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]            rsp_sel_q, rsp_sel_d;
  logic                  misaligned_q, misaligned_d;
  logic                  req_ready_q, req_ready_d;
  logic                  stall_q, stall_d;

  logic                  align_mis_s;
  logic [BE_WIDTH-1:0]   align_be_s;
  logic [DATA_WIDTH-1:0] align_wdata_s;

  mem_store_align u_store_align (
    .we         (req_we),
    .size       (req_size),
    .offset     (req_addr[1:0]),
    .wdata      (req_wdata),
    .misaligned (align_mis_s),
    .be         (align_be_s),
    .wdata_rep  (align_wdata_s)
  );

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d          = state_q;
    we_d             = we_q;
    size_d           = size_q;
    offset_d         = offset_q;
    dmem_req_valid_d = dmem_req_valid_q;
    dmem_addr_d      = dmem_addr_q;
    dmem_be_d        = dmem_be_q;
    dmem_wdata_d     = dmem_wdata_q;
    rsp_valid_d      = 1'b0;
    rsp_data_d       = rsp_data_q;
    rsp_sel_d        = rsp_sel_q;
    misaligned_d     = 1'b0;
    req_ready_d      = req_ready_q;
    stall_d          = stall_q;
    case (state_q)
      IDLE: begin
        if (req_valid && align_mis_s) begin
          // Rejected: complete immediately with zero data, no memory access.
          misaligned_d = 1'b1;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = '0;
          rsp_sel_d    = req_size;
        end else if (req_valid) begin
          state_d          = REQ;
          we_d             = req_we;
          size_d           = req_size;
          offset_d         = req_addr[1:0];
          dmem_req_valid_d = 1'b1;
          dmem_addr_d      = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          dmem_be_d        = align_be_s;
          dmem_wdata_d     = align_wdata_s;
          req_ready_d      = 1'b0;
          stall_d          = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dmem_req_ready && we_q) begin
          state_d          = IDLE;
          dmem_req_valid_d = 1'b0;
          rsp_valid_d      = 1'b1;
          rsp_data_d       = '0;
          rsp_sel_d        = size_q;
          req_ready_d      = 1'b1;
          stall_d          = 1'b0;
        end else if (dmem_req_ready) begin
          state_d          = WAIT;
          dmem_req_valid_d = 1'b0;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          // Move the addressed byte/half down to lane 0 for Byte_unit.
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = dmem_rsp_rdata >> {offset_q, 3'b000};
          rsp_sel_d   = size_q;
          req_ready_d = 1'b1;
          stall_d     = 1'b0;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d          = IDLE;
        dmem_req_valid_d = 1'b0;
        req_ready_d      = 1'b1;
        stall_d          = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      we_q             <= 1'b0;
      size_q           <= 2'b00;
      offset_q         <= 2'b00;
      dmem_req_valid_q <= 1'b0;
      dmem_addr_q      <= '0;
      dmem_be_q        <= '0;
      dmem_wdata_q     <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= '0;
      rsp_sel_q        <= 2'b00;
      misaligned_q     <= 1'b0;
      req_ready_q      <= 1'b1;
      stall_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      we_q             <= we_d;
      size_q           <= size_d;
      offset_q         <= offset_d;
      dmem_req_valid_q <= dmem_req_valid_d;
      dmem_addr_q      <= dmem_addr_d;
      dmem_be_q        <= dmem_be_d;
      dmem_wdata_q     <= dmem_wdata_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_data_q       <= rsp_data_d;
      rsp_sel_q        <= rsp_sel_d;
      misaligned_q     <= misaligned_d;
      req_ready_q      <= req_ready_d;
      stall_q          <= stall_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign stall          = stall_q;
  assign dmem_req_valid = dmem_req_valid_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_be        = dmem_be_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_sel        = rsp_sel_q;
  assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: a vector table of single transactions
// plus hand-written sequences for memory back-pressure, response latency,
// reset during WAIT and back-to-back loads.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_sel;
  logic        misaligned;
  logic        stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_sel        (rsp_sel),
    .misaligned     (misaligned),
    .stall          (stall)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    //            we    size   addr          wdata         rdata        mis   e_addr        e_be     e_wdata       e_rdata
    vecs[0]  = '{1'b1, 2'b00, 32'h0000_1003, 32'h0000_00AB, 32'h0,       1'b0, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0};
    vecs[1]  = '{1'b1, 2'b01, 32'h0000_2002, 32'h0000_BEEF, 32'h0,       1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[2]  = '{1'b1, 2'b10, 32'h0000_4000, 32'h1234_5678, 32'h0,       1'b0, 32'h0000_4000, 4'b1111, 32'h1234_5678, 32'h0};
    vecs[3]  = '{1'b0, 2'b00, 32'h0000_5001, 32'h0,         32'h1122_3344, 1'b0, 32'h0000_5000, 4'b0000, 32'h0,       32'h0011_2233};
    vecs[4]  = '{1'b0, 2'b01, 32'h0000_2002, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0000_2000, 4'b0000, 32'h0,       32'h0000_DEAD};
    vecs[5]  = '{1'b0, 2'b10, 32'h0000_3000, 32'h0,         32'hCAFE_F00D, 1'b0, 32'h0000_3000, 4'b0000, 32'h0,       32'hCAFE_F00D};
    vecs[6]  = '{1'b0, 2'b00, 32'h0000_6003, 32'h0,         32'h9A00_0000, 1'b0, 32'h0000_6000, 4'b0000, 32'h0,       32'h0000_009A};
    vecs[7]  = '{1'b0, 2'b10, 32'h0000_3001, 32'h0,         32'h0,       1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 2'b01, 32'h0000_7001, 32'h0000_5555, 32'h0,       1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, 2'b11, 32'h0000_8000, 32'h0,         32'h0,       1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 2'b00, 32'h0000_0000, 32'hDEAD_BE5A, 32'h0,       1'b0, 32'h0000_0000, 4'b0001, 32'h5A5A_5A5A, 32'h0};
    vecs[11] = '{1'b1, 2'b01, 32'h0000_0000, 32'hFFFF_1234, 32'h0,       1'b0, 32'h0000_0000, 4'b0011, 32'h1234_1234, 32'h0};

    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_we         = 1'b0;
    req_size       = 2'b00;
    req_addr       = 32'h0;
    req_wdata      = 32'h0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = 32'h0;

    // Reset values
    repeat (2) step();
    chk("rst_req_ready",  {31'h0, req_ready}, 32'd1);
    chk("rst_stall",      {31'h0, stall}, 32'd0);
    chk("rst_dmem_valid", {31'h0, dmem_req_valid}, 32'd0);
    chk("rst_dmem_we",    {31'h0, dmem_we}, 32'd0);
    chk("rst_dmem_addr",  dmem_addr, 32'h0);
    chk("rst_dmem_be",    {28'h0, dmem_be}, 32'h0);
    chk("rst_dmem_wdata", dmem_wdata, 32'h0);
    chk("rst_rsp_valid",  {31'h0, rsp_valid}, 32'd0);
    chk("rst_rsp_data",   rsp_data, 32'h0);
    chk("rst_rsp_sel",    {30'h0, rsp_sel}, 32'd0);
    chk("rst_misaligned", {31'h0, misaligned}, 32'd0);
    rst_n = 1'b1;
    step();

    // Table of single transactions, memory always ready, load data next cycle
    dmem_req_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].mis) begin
        chk("mis_pulse",     {31'h0, misaligned}, 32'd1);
        chk("mis_rsp_valid", {31'h0, rsp_valid}, 32'd1);
        chk("mis_rsp_data",  rsp_data, 32'h0);
        chk("mis_no_dmem",   {31'h0, dmem_req_valid}, 32'd0);
        chk("mis_ready",     {31'h0, req_ready}, 32'd1);
        step();
        chk("mis_one_cycle", {31'h0, misaligned}, 32'd0);
        chk("mis_rsp_once",  {31'h0, rsp_valid}, 32'd0);
        chk("mis_no_dmem2",  {31'h0, dmem_req_valid}, 32'd0);
      end else begin
        chk("req_valid",  {31'h0, dmem_req_valid}, 32'd1);
        chk("req_we",     {31'h0, dmem_we}, {31'h0, vecs[i].we});
        chk("req_addr",   dmem_addr, vecs[i].e_addr);
        chk("req_be",     {28'h0, dmem_be}, {28'h0, vecs[i].e_be});
        chk("req_wdata",  dmem_wdata, vecs[i].e_wdata);
        chk("req_stall",  {31'h0, stall}, 32'd1);
        chk("req_busy",   {31'h0, req_ready}, 32'd0);
        step();
        if (vecs[i].we) begin
          chk("st_rsp_valid", {31'h0, rsp_valid}, 32'd1);
          chk("st_rsp_data",  rsp_data, 32'h0);
          chk("st_rsp_sel",   {30'h0, rsp_sel}, {30'h0, vecs[i].size});
          chk("st_ready",     {31'h0, req_ready}, 32'd1);
          chk("st_stall",     {31'h0, stall}, 32'd0);
          chk("st_dmem_drop", {31'h0, dmem_req_valid}, 32'd0);
        end else begin
          chk("ld_wait_rsp",   {31'h0, rsp_valid}, 32'd0);
          chk("ld_wait_stall", {31'h0, stall}, 32'd1);
          chk("ld_dmem_drop",  {31'h0, dmem_req_valid}, 32'd0);
          dmem_rsp_valid = 1'b1;
          dmem_rsp_rdata = vecs[i].rdata;
          step();
          dmem_rsp_valid = 1'b0;
          chk("ld_rsp_valid", {31'h0, rsp_valid}, 32'd1);
          chk("ld_rsp_data",  rsp_data, vecs[i].e_rdata);
          chk("ld_rsp_sel",   {30'h0, rsp_sel}, {30'h0, vecs[i].size});
          chk("ld_ready",     {31'h0, req_ready}, 32'd1);
          chk("ld_stall",     {31'h0, stall}, 32'd0);
        end
      end
    end
    step();

    // Load half 0x2002 with three wait cycles before the response
    issue(1'b0, 2'b01, 32'h0000_2002, 32'h0);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("lat_stall",     {31'h0, stall}, 32'd1);
      chk("lat_no_rsp",    {31'h0, rsp_valid}, 32'd0);
      chk("lat_not_ready", {31'h0, req_ready}, 32'd0);
      step();
    end
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'hDEAD_BEEF;
    step();
    dmem_rsp_valid = 1'b0;
    chk("lat_rsp_valid", {31'h0, rsp_valid}, 32'd1);
    chk("lat_rsp_data",  rsp_data, 32'h0000_DEAD);
    chk("lat_rsp_sel",   {30'h0, rsp_sel}, 32'd1);
    chk("lat_stall_end", {31'h0, stall}, 32'd0);
    step();

    // Store word with memory not ready for 5 cycles
    dmem_req_ready = 1'b0;
    issue(1'b1, 2'b10, 32'h0000_4000, 32'h1234_5678);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'h0, dmem_req_valid}, 32'd1);
      chk("bp_addr",  dmem_addr, 32'h0000_4000);
      chk("bp_be",    {28'h0, dmem_be}, 32'hF);
      chk("bp_wdata", dmem_wdata, 32'h1234_5678);
      chk("bp_stall", {31'h0, stall}, 32'd1);
      chk("bp_no_rsp", {31'h0, rsp_valid}, 32'd0);
      step();
    end
    dmem_req_ready = 1'b1;
    step();
    chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'd1);
    chk("bp_ready",     {31'h0, req_ready}, 32'd1);
    chk("bp_rsp_sel",   {30'h0, rsp_sel}, 32'd2);
    step();
    chk("bp_rsp_once",  {31'h0, rsp_valid}, 32'd0);

    // Reset asserted while a load waits for its response
    issue(1'b0, 2'b10, 32'h0000_3000, 32'h0);
    step();
    chk("rw_in_wait", {31'h0, stall}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rw_ready",      {31'h0, req_ready}, 32'd1);
    chk("rw_stall",      {31'h0, stall}, 32'd0);
    chk("rw_dmem_valid", {31'h0, dmem_req_valid}, 32'd0);
    chk("rw_dmem_addr",  dmem_addr, 32'h0);
    chk("rw_rsp_sel",    {30'h0, rsp_sel}, 32'd0);
    step();
    rst_n = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'hFFFF_FFFF;
    step();
    dmem_rsp_valid = 1'b0;
    chk("rw_rsp_ignored",  {31'h0, rsp_valid}, 32'd0);
    chk("rw_data_ignored", rsp_data, 32'h0);
    chk("rw_ready_after",  {31'h0, req_ready}, 32'd1);
    chk("rw_stall_after",  {31'h0, stall}, 32'd0);

    // Back-to-back loads: second accepted in the first one's completion cycle
    issue(1'b0, 2'b10, 32'h0000_0010, 32'h0);
    step();
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h1111_1111;
    step();
    dmem_rsp_valid = 1'b0;
    chk("b2b_rsp1_valid", {31'h0, rsp_valid}, 32'd1);
    chk("b2b_rsp1_data",  rsp_data, 32'h1111_1111);
    chk("b2b_rsp1_ready", {31'h0, req_ready}, 32'd1);
    issue(1'b0, 2'b10, 32'h0000_0014, 32'h0);
    chk("b2b_req2_valid", {31'h0, dmem_req_valid}, 32'd1);
    chk("b2b_req2_addr",  dmem_addr, 32'h0000_0014);
    chk("b2b_req2_norsp", {31'h0, rsp_valid}, 32'd0);
    step();
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h2222_2222;
    step();
    dmem_rsp_valid = 1'b0;
    chk("b2b_rsp2_valid", {31'h0, rsp_valid}, 32'd1);
    chk("b2b_rsp2_data",  rsp_data, 32'h2222_2222);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
